// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - per-cycle host/core arbiter for the shared data memory with locked bursts
module dmem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic                 host_lock,
    input  logic [AW-1:0]        host_addr,
    input  logic [DW-1:0]        host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    input  logic [NCORES-1:0]    core_req,
    input  logic [NCORES-1:0]    core_we,
    input  logic [NCORES-1:0]    core_lock,
    input  logic [NCORES*AW-1:0] core_addr,
    input  logic [NCORES*DW-1:0] core_wdata,
    output logic [NCORES-1:0]    core_gnt,
    output logic [NCORES-1:0]    core_rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DW-1:0]        mem_rdata
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic          owner_host;
    logic [IW-1:0] owner_idx;
    logic [IW-1:0] rr_ptr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic [IW-1:0] core_sel;
    logic          any_gnt;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Round-robin search starting at rr_ptr, wrapping modulo NCORES.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NCORES; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NCORES);
            if (!found && core_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign core_sel = (state == ST_LOCKED) ? owner_idx : win_idx;

    always_comb begin
        host_gnt = 1'b0;
        core_gnt = '0;
        if (!RESET) begin
            if (state == ST_LOCKED) begin
                if (owner_host) host_gnt = host_req;
                else            core_gnt[owner_idx] = core_req[owner_idx];
            end else if (host_req) begin
                host_gnt = 1'b1;
            end else if (found) begin
                core_gnt[win_idx] = 1'b1;
            end
        end
    end

    assign any_gnt   = host_gnt | (|core_gnt);
    assign sel_we    = host_gnt ? host_we    : core_we[core_sel];
    assign sel_lock  = host_gnt ? host_lock  : core_lock[core_sel];
    assign sel_addr  = host_gnt ? host_addr  : core_addr[int'(core_sel)*AW +: AW];
    assign sel_wdata = host_gnt ? host_wdata : core_wdata[int'(core_sel)*DW +: DW];

    assign mem_we    = any_gnt & sel_we;
    assign mem_re    = any_gnt & ~sel_we;
    assign mem_addr  = any_gnt ? sel_addr  : addr_q;
    assign mem_wdata = any_gnt ? sel_wdata : wdata_q;
    assign rdata     = mem_rdata;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= ST_ARB;
            owner_host  <= 1'b0;
            owner_idx   <= '0;
            rr_ptr      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            host_rvalid <= 1'b0;
            core_rvalid <= '0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            core_rvalid <= core_gnt & ~core_we;
            if (any_gnt) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (|core_gnt)
                rr_ptr <= (int'(core_sel) == NCORES-1) ? '0 : core_sel + 1'b1;
            // An ungranted locked cycle means the owner dropped req: the lock is abandoned.
            if (state == ST_ARB) begin
                if (any_gnt && sel_lock) begin
                    state      <= ST_LOCKED;
                    owner_host <= host_gnt;
                    owner_idx  <= core_sel;
                end
            end else if (!any_gnt || !sel_lock) begin
                state <= ST_ARB;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a synchronous memory model
module tb_dmem_arbiter;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          RESET;
    logic          host_req, host_we, host_lock;
    logic [15:0]   host_addr, host_wdata;
    logic          host_gnt, host_rvalid;
    logic [NC-1:0] core_req, core_we, core_lock;
    logic [NC*16-1:0] core_addr, core_wdata;
    logic [NC-1:0] core_gnt, core_rvalid;
    logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
    logic          mem_we, mem_re;

    logic [15:0]   mem [0:1023];
    int            checks = 0;
    int            errors = 0;
    int            we_cnt = 0;

    typedef struct packed { logic [3:0] id; logic [15:0] addr; logic we; } gexp_t;
    typedef struct packed { logic [3:0] id; logic [15:0] data; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    dmem_arbiter #(.NCORES(NC), .AW(16), .DW(16)) dut (
        .clk(clk), .RESET(RESET),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    end

    // Requester id: host = 8, core k = k, illegal combination = 15.
    function automatic logic [3:0] who(input logic h, input logic [NC-1:0] c);
        logic [3:0] r;
        r = 4'd15;
        if (h && c == '0) r = 4'd8;
        else if (!h && $onehot(c))
            for (int k = 0; k < NC; k++) if (c[k]) r = 4'(k);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (mem_we) we_cnt++;
        if (host_gnt || core_gnt != '0) begin
            if (gq.size() == 0) chk("unexpected_grant", {28'd0, who(host_gnt, core_gnt)}, 32'hffff_ffff);
            else begin
                ge = gq.pop_front();
                chk("grant_id_addr_we", {11'd0, who(host_gnt, core_gnt), mem_addr, mem_we},
                    {11'd0, ge.id, ge.addr, ge.we});
            end
        end
        if (host_rvalid || core_rvalid != '0) begin
            if (rq.size() == 0) chk("unexpected_rvalid", {28'd0, who(host_rvalid, core_rvalid)}, 32'hffff_ffff);
            else begin
                re = rq.pop_front();
                chk("rvalid_id_data", {12'd0, who(host_rvalid, core_rvalid), rdata},
                    {12'd0, re.id, re.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eg(input int id, input int addr, input logic we);
        gq.push_back({4'(id), 16'(addr), we});
    endtask

    task automatic er(input int id, input int data);
        rq.push_back({4'(id), 16'(data)});
    endtask

    task automatic set_core(input int k, input logic req, input logic we, input logic lk,
                            input int addr, input int wd);
        core_req[k]          = req;
        core_we[k]           = we;
        core_lock[k]         = lk;
        core_addr[k*16 +: 16]  = 16'(addr);
        core_wdata[k*16 +: 16] = 16'(wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_lock = 1'b0;
        host_addr = '0; host_wdata = '0;
        core_req = '1; core_we = '1; core_lock = '0;
        core_addr = '0; core_wdata = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_gnt", {27'd0, host_gnt, core_gnt}, 32'd0);
            chk("reset_rvalid", {27'd0, host_rvalid, core_rvalid}, 32'd0);
            chk("reset_strobes", {30'd0, mem_we, mem_re}, 32'd0);
            step();
        end
        RESET = 1'b0;

        // Host preload with cores still requesting; host must win every cycle.
        for (int a = 0; a < 1000; a++) begin
            host_addr = 16'(a); host_wdata = 16'(a); host_we = 1'b1;
            eg(8, a, 1'b1);
            step();
        end
        core_req = '0;
        chk("preload_we_count", 32'(we_cnt), 32'd1000);
        host_addr = 16'd997; host_we = 1'b0;
        eg(8, 997, 1'b0); er(8, 997);
        step();
        host_req = 1'b0;
        step();

        // Round robin: 0,1,2,3,0,1,2,3 then core 2 alone then 3,0,1,2.
        for (int k = 0; k < NC; k++) set_core(k, 1'b1, 1'b1, 1'b0, 200 + k, 16'hc000 + k);
        for (int i = 0; i < 8; i++) begin
            eg(i % 4, 200 + i % 4, 1'b1);
            step();
        end
        core_req = 4'b0100;
        eg(2, 202, 1'b1);
        step();
        core_req = 4'b1111;
        eg(3, 203, 1'b1); step();
        eg(0, 200, 1'b1); step();
        eg(1, 201, 1'b1); step();
        eg(2, 202, 1'b1); step();
        core_req = '0;
        step();

        // Locked burst by core 1 while host and core 0 wait.
        set_core(1, 1'b1, 1'b0, 1'b1, 10, 0);
        eg(1, 10, 1'b0); er(1, 10);
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'd300; host_wdata = 16'haaaa;
        set_core(0, 1'b1, 1'b1, 1'b0, 301, 16'hbbbb);
        set_core(1, 1'b1, 1'b0, 1'b1, 11, 0);
        eg(1, 11, 1'b0); er(1, 11);
        step();
        set_core(1, 1'b1, 1'b0, 1'b1, 12, 0);
        eg(1, 12, 1'b0); er(1, 12);
        step();
        set_core(1, 1'b1, 1'b0, 1'b0, 13, 0);
        eg(1, 13, 1'b0); er(1, 13);
        step();
        core_req[1] = 1'b0;
        eg(8, 300, 1'b1);
        step();
        host_req = 1'b0;
        eg(0, 301, 1'b1);
        step();
        core_req[0] = 1'b0;
        step();

        // Abandoned lock: core 2 locks then drops req; core 3 waits.
        set_core(2, 1'b1, 1'b1, 1'b1, 400, 16'h2222);
        set_core(3, 1'b1, 1'b1, 1'b0, 403, 16'h3333);
        eg(2, 400, 1'b1);
        step();
        core_req[2] = 1'b0;
        @(negedge clk);
        chk("abandon_no_grant", {27'd0, host_gnt, core_gnt}, 32'd0);
        step();
        eg(3, 403, 1'b1);
        step();
        core_req[3] = 1'b0;
        step();

        // Back-to-back reads to different cores.
        set_core(0, 1'b1, 1'b0, 1'b0, 5, 0);
        eg(0, 5, 1'b0); er(0, 5);
        step();
        core_req[0] = 1'b0;
        set_core(3, 1'b1, 1'b0, 1'b0, 6, 0);
        eg(3, 6, 1'b0); er(3, 6);
        step();
        core_req[3] = 1'b0;
        step();
        step();

        // Same pattern with reset in the second cycle: no strobe, and the second rvalid never appears.
        set_core(0, 1'b1, 1'b0, 1'b0, 5, 0);
        eg(0, 5, 1'b0); er(0, 5);
        step();
        core_req[0] = 1'b0;
        set_core(3, 1'b1, 1'b0, 1'b0, 6, 0);
        RESET = 1'b1;
        @(negedge clk);
        chk("reset_mid_no_strobe", {26'd0, mem_we, mem_re, core_gnt}, 32'd0);
        step();
        RESET = 1'b0;
        core_req[3] = 1'b0;
        @(negedge clk);
        chk("reset_rvalid_cleared", {28'd0, core_rvalid}, 32'd0);
        step();
        step();

        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single 16-bit data memory between the NCORES matrix-multiplication cores and the host load/unload port. It replaces the static host/core/readout memory-select with per-cycle arbitration and supports locked bursts. It sits between the cores and the data memory inside `top`. The host port keeps priority so preload and result readout can proceed while cores are idle or stalled.

## Interface
- NCORES, 4, number of core requesters (2..8)
- AW, 16, address width
- DW, 16, data width
- clk  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- host_req / host_we / host_lock  in  1 each  host access request, write enable, burst lock
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  rdata holds host read result
- core_req / core_we / core_lock  in  NCORES each  per-core request, write enable, lock
- core_addr  in  NCORES*AW  core k address at bits [k*AW +: AW]
- core_wdata  in  NCORES*DW  core k write data at bits [k*DW +: DW]
- core_gnt  out  NCORES  one-hot core grant
- core_rvalid  out  NCORES  one-hot, rdata holds core k read result
- rdata  out  DW  shared read data, mem_rdata passed through
- mem_addr / mem_wdata  out  AW / DW  memory address and write data
- mem_we / mem_re  out  1 each  memory write and read strobes
- mem_rdata  in  DW  synchronous-read data, valid one cycle after mem_re

## Operation
- State is ARB or LOCKED. LOCKED stores owner: host, or core index 0..NCORES-1.
- Grants are combinational from registered state and the current requests. At most one grant is high per cycle, to host or core.
- ARB state:
  - host_req wins.
  - Otherwise the first requesting core at or after rr_ptr, searching upward and wrapping, wins.
- Round-robin pointer:
  - A core grant to k sets rr_ptr = (k+1) mod NCORES.
  - Host grants leave rr_ptr unchanged.
- LOCKED state:
  - Only the owner can be granted, and only while its req is high.
  - All other requests, including host, are blocked.
- Entering LOCKED: a grant whose lock input is high moves the state to LOCKED with owner = grantee.
- Leaving LOCKED: return to ARB at the edge of either
  - a granted owner cycle with lock low, or
  - any cycle where the owner's req is low (abandoned lock).
- A granted cycle drives:
  - mem_addr / mem_wdata from the grantee,
  - mem_we = we,
  - mem_re = ~we.
  The access completes at that rising edge.
- Requester handshake: hold req/addr/wdata/we until it sees gnt high. It may present the next access in the following cycle.
- Read return: the rvalid bit of the grantee is registered. It is high exactly one cycle after the granted read, with rdata = mem_rdata.
- Writes produce no rvalid.
- With no grant: mem_we = mem_re = 0; mem_addr / mem_wdata hold the last granted values.

## Timing
- Reset values while RESET is high and after it falls:
  - state ARB, rr_ptr 0, no owner,
  - all gnt 0, all rvalid 0,
  - mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0.
- Reset forces the grants low in the same cycle (the only combinational dependency on RESET).
- Throughput: one access per cycle. Back-to-back grants to the same or different requesters are allowed.
- Read latency: the grant cycle is N; rvalid and rdata are valid in cycle N+1. Reads to different requesters in cycles N and N+1 produce rvalids in N+1 and N+2 with no overlap.
- Mid-burst reset: the lock is released, any pending rvalid is cleared, and no memory strobe is issued in the reset cycle.
- Host and core requesting simultaneously in ARB: host is granted; the core waits, and rr_ptr does not move.
- rr_ptr wrap: a grant to core NCORES-1 sets rr_ptr 0.

## Test plan
- Reset check: RESET high for 3 cycles with all reqs high -> every gnt, rvalid, mem_we and mem_re stays 0; after release, host is granted first.
- Host preload: host writes 1000 words, data = address, one per cycle. Then host reads addr 997 -> host_gnt every cycle, mem_we high 1000 cycles; host_rvalid one cycle after the read with rdata = 997.
- Round robin, NCORES=4: all cores hold req continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3. After core 2 alone is granted, all four requesting -> order 3,0,1,2.
- Lock burst: core 1 reads addrs 10..13 with lock high for the first 3 grants, while host_req and core 0 req are held high -> 4 consecutive grants to core 1. The host is granted in the next cycle, core 0 after that.
- Abandoned lock: core 2 granted with lock high, then drops req -> state returns to ARB the next cycle; a waiting core 3 is granted within 2 cycles.
- Read pipelining: core 0 reads addr 5 in cycle N, core 3 reads addr 6 in cycle N+1 -> core_rvalid[0] in N+1 with rdata 5, core_rvalid[3] in N+2 with rdata 6. Reset asserted in N+1 suppresses the N+2 rvalid.
